// File: rtl/rle_decoding_queue_if.sv
// Serial link between the coding-queue stream, the run-length decoder and the
// downstream bit consumer.
//   bit_input, wrreq : encoded bit and its valid strobe (producer -> decoder)
//   full             : decoder symbol buffer is full, code bits are dropped
//   bit_output       : decoded bit, valid while bit_valid is high
//   rdreq            : consumer takes bit_output when bit_valid && rdreq
//   run_done         : one-cycle pulse after the last bit of a run is taken
//   overflow         : sticky, a code bit arrived while full
//   bit_count        : decoded bits consumed, modulo 2^16
interface rle_decoding_queue_if;
  logic        bit_input;
  logic        wrreq;
  logic        full;
  logic        bit_output;
  logic        bit_valid;
  logic        rdreq;
  logic        run_done;
  logic        overflow;
  logic [15:0] bit_count;

  // Producer/consumer side.
  modport master (
    output bit_input, wrreq, rdreq,
    input  full, bit_output, bit_valid, run_done, overflow, bit_count
  );

  // Decoder side.
  modport slave (
    input  bit_input, wrreq, rdreq,
    output full, bit_output, bit_valid, run_done, overflow, bit_count
  );
endinterface

// File: rtl/rle_decoding_queue.sv
// Run-length decoder at the receiving end of the coding-queue serial stream.
// Code bits arrive one per accepted wrreq as {value, length[LEN_W-1:0]} MSB
// first. Parsed symbols go into a 2-entry FIFO; the expander pops a symbol
// and emits its value length+1 times, one bit per bit_valid && rdreq
// handshake, reloading on the final handshake so consecutive runs stream
// without a bubble.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : rle_decoding_queue_if.slave (code input, decoded output, status)
module rle_decoding_queue #(
  parameter int LEN_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  rle_decoding_queue_if.slave bus
);

  localparam int IDX_W = (LEN_W > 1) ? $clog2(LEN_W) : 1;
  localparam int REM_W = LEN_W + 1;  // holds up to 2^LEN_W

  typedef enum logic {
    S_VAL,
    S_LEN
  } parse_state_e;

  typedef struct packed {
    logic             value;
    logic [LEN_W-1:0] len;
  } symbol_t;

  // Parser state
  parse_state_e     state_q, state_d;
  logic             val_q, val_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Symbol buffer
  symbol_t          buf_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;

  // Expander and registered outputs
  logic             run_val_q, run_val_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             full_q;
  logic             bit_output_q;
  logic             bit_valid_q;
  logic             run_done_q;
  logic             overflow_q;
  logic [15:0]      bit_count_q;

  logic             accept;
  logic             push;
  logic             pop;
  logic             handshake;
  logic             last_bit;
  logic [LEN_W-1:0] len_shift;
  symbol_t          push_sym;
  symbol_t          head;

  // Bits offered while full are dropped; they never reach the parser.
  assign accept    = bus.wrreq && !full_q;
  assign handshake = (rem_q != '0) && bus.rdreq;
  assign last_bit  = handshake && (rem_q == REM_W'(1));
  // Reload either from idle or on the run's final handshake, so the next run
  // is presented on the very next cycle. The buffer is only read from its
  // registered contents, so a symbol pushed this edge is poppable next edge.
  assign pop       = (count_q != 2'd0) && ((rem_q == '0) || last_bit);
  assign head      = buf_q[rd_ptr_q];

  // Shifting in the incoming length bit; the cast drops the old MSB.
  assign len_shift = LEN_W'({len_q, bus.bit_input});
  assign push_sym  = '{value: val_q, len: len_shift};

  // Parser next state.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    val_d   = val_q;
    len_d   = len_q;
    idx_d   = idx_q;
    push    = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_VAL: begin
          val_d   = bus.bit_input;
          idx_d   = IDX_W'(LEN_W - 1);
          state_d = S_LEN;
        end
        S_LEN: begin
          len_d = len_shift;
          if (idx_q == '0) begin
            push    = 1'b1;
            state_d = S_VAL;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
        default: state_d = S_VAL;
      endcase
    end
  end

  // Buffer occupancy and expander next state.
  always_comb begin
    count_d   = count_q;
    rem_d     = rem_q;
    run_val_d = run_val_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    if (pop) begin
      rem_d     = REM_W'(head.len) + REM_W'(1);
      run_val_d = head.value;
    end else if (handshake) begin
      rem_d = rem_q - REM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_VAL;
      val_q        <= 1'b0;
      len_q        <= '0;
      idx_q        <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      run_val_q    <= 1'b0;
      rem_q        <= '0;
      full_q       <= 1'b0;
      bit_output_q <= 1'b0;
      bit_valid_q  <= 1'b0;
      run_done_q   <= 1'b0;
      overflow_q   <= 1'b0;
      bit_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      val_q        <= val_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q      <= count_d;
      run_val_q    <= run_val_d;
      rem_q        <= rem_d;
      full_q       <= (count_d == 2'd2);
      bit_output_q <= (rem_d != '0) ? run_val_d : 1'b0;
      bit_valid_q  <= (rem_d != '0);
      run_done_q   <= last_bit;
      overflow_q   <= overflow_q | (bus.wrreq && full_q);
      bit_count_q  <= bit_count_q + 16'(handshake);
    end
  end

  // NOTE: buffer storage is not reset; occupancy and pointers are, and an
  // entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= push_sym;
  end

  assign bus.full       = full_q;
  assign bus.bit_output = bit_output_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.run_done   = run_done_q;
  assign bus.overflow   = overflow_q;
  assign bus.bit_count  = bit_count_q;

endmodule

// File: tb/tb_rle_decoding_queue.sv
// Self-checking bench for rle_decoding_queue. The reference model expands
// each symbol sent into value repeated length+1 times and keeps the expected
// bit stream in a queue; the bench records every handshaken bit and the
// cycle it was taken in, and counts run_done pulses.
module tb_rle_decoding_queue;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rle_decoding_queue_if bus ();

  rle_decoding_queue #(.LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   pulses;
  int   hs;
  bit   record = 1'b1;
  logic obs[$];
  int   obs_t[$];
  logic exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // One clock cycle: sample outputs at the falling edge, then drive inputs
  // for the next rising edge. A handshake happens when bit_valid && rdreq.
  task automatic cycle(input logic wr, input logic b, input logic rd,
                       input bit guarded, output bit took);
    @(negedge clk);
    took          = wr && !bus.full;
    bus.wrreq     = (guarded && bus.full) ? 1'b0 : wr;
    bus.bit_input = b;
    bus.rdreq     = rd;
    if (bus.bit_valid && rd) begin
      hs++;
      if (record) begin
        obs.push_back(bus.bit_output);
        obs_t.push_back(cyc);
      end
    end
    if (bus.run_done) pulses++;
  endtask

  task automatic idle(input logic rd, input int n);
    bit t;
    repeat (n) cycle(1'b0, 1'b0, rd, 1'b1, t);
  endtask

  function automatic logic pick_rd(input int rd_pct);
    return ($urandom_range(99, 0) < rd_pct);
  endfunction

  task automatic send_bit(input logic b, input int rd_pct);
    bit took = 1'b0;
    int guard = 0;
    do begin
      cycle(1'b1, b, pick_rd(rd_pct), 1'b1, took);
      guard++;
    end while (!took && guard < 300);
    if (!took) begin
      total++; bad++;
      $display("FAIL send_bit: blocked by full for %0d cycles, required acceptance", guard);
    end
  endtask

  task automatic send_symbol(input logic v, input int len, input int gap_max, input int rd_pct);
    logic [LEN_W:0] word;
    bit t;
    word = {v, LEN_W'(len)};
    for (int i = LEN_W; i >= 0; i--) begin
      repeat ($urandom_range(gap_max, 0)) cycle(1'b0, 1'b0, pick_rd(rd_pct), 1'b1, t);
      send_bit(word[i], rd_pct);
    end
    if (record) for (int k = 0; k <= len; k++) exp_q.push_back(v);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; bus.wrreq = 1'b0; bus.rdreq = 1'b0; bus.bit_input = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    obs.delete(); obs_t.delete(); exp_q.delete();
    pulses = 0; hs = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (bus.full !== 1'b0)       begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
    total++; if (bus.bit_output !== 1'b0) begin bad++; $display("FAIL reset_bit_output: got %b want 0", bus.bit_output); end
    total++; if (bus.bit_valid !== 1'b0)  begin bad++; $display("FAIL reset_bit_valid: got %b want 0", bus.bit_valid); end
    total++; if (bus.run_done !== 1'b0)   begin bad++; $display("FAIL reset_run_done: got %b want 0", bus.run_done); end
    total++; if (bus.overflow !== 1'b0)   begin bad++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    total++; if (bus.bit_count !== 16'd0) begin bad++; $display("FAIL reset_bit_count: got %0d want 0", bus.bit_count); end
  endtask

  task automatic test_nominal();
    logic [15:0] want;
    want = 16'b0011110000001111;
    apply_reset();
    send_symbol(1'b0, 1, 0, 100);
    send_symbol(1'b1, 3, 0, 100);
    send_symbol(1'b0, 5, 0, 100);
    send_symbol(1'b1, 3, 0, 100);
    idle(1'b1, 30);
    total++; if (obs.size() != 16) begin bad++; $display("FAIL nominal_len: got %0d want 16", obs.size()); end
    for (int i = 0; i < 16 && i < obs.size(); i++) begin
      total++; if (obs[i] !== want[15-i]) begin bad++; $display("FAIL nominal_bit%0d: got %b want %b", i, obs[i], want[15-i]); end
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL nominal_run_done: got %0d pulses want 4", pulses); end
    total++; if (bus.bit_count !== 16'd16) begin bad++; $display("FAIL nominal_bit_count: got %0d want 16", bus.bit_count); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL nominal_overflow: got %b want 0", bus.overflow); end
  endtask

  task automatic test_latency();
    apply_reset();
    send_symbol(1'b1, 0, 3, 0);   // last length bit is sampled on the next edge
    idle(1'b0, 1);
    total++; if (bus.bit_valid !== 1'b0) begin bad++; $display("FAIL latency_early: bit_valid got %b want 0", bus.bit_valid); end
    idle(1'b1, 1);
    total++; if (bus.bit_valid !== 1'b1) begin bad++; $display("FAIL latency_valid: bit_valid got %b want 1", bus.bit_valid); end
    idle(1'b1, 6);
    total++; if (obs.size() != 1) begin bad++; $display("FAIL latency_len: got %0d bits want 1", obs.size()); end
    if (obs.size() > 0) begin
      total++; if (obs[0] !== 1'b1) begin bad++; $display("FAIL latency_bit: got %b want 1", obs[0]); end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL latency_run_done: got %0d want 1", pulses); end
  endtask

  task automatic test_backpressure();
    bit t;
    apply_reset();
    send_symbol(1'($urandom_range(1, 0)), $urandom_range(15, 0), 0, 0);
    send_symbol(1'($urandom_range(1, 0)), $urandom_range(15, 0), 0, 0);
    idle(1'b0, 1);
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL bp_full_two: got %b want 0", bus.full); end
    send_symbol(1'($urandom_range(1, 0)), $urandom_range(15, 0), 0, 0);
    idle(1'b0, 1);
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL bp_full_three: got %b want 1", bus.full); end
    repeat (6) cycle(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b0, t);  // dropped bits
    idle(1'b0, 1);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow_set: got %b want 1", bus.overflow); end
    idle(1'b1, exp_q.size() + 10);
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL bp_full_drained: got %b want 0", bus.full); end
    // Parser must still be aligned on a value bit after the dropped bits.
    send_symbol(1'($urandom_range(1, 0)), $urandom_range(15, 0), 0, 100);
    idle(1'b1, 30);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow_sticky: got %b want 1", bus.overflow); end
    total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL bp_len: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL bp_bit%0d: got %b want %b", i, obs[i], exp_q[i]); end
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL bp_run_done: got %0d want 4", pulses); end
  endtask

  task automatic test_max_run();
    apply_reset();
    send_symbol(1'b1, 15, 0, 100);
    idle(1'b1, 30);
    total++; if (obs.size() != 16) begin bad++; $display("FAIL max_len: got %0d want 16", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      total++; if (obs[i] !== 1'b1) begin bad++; $display("FAIL max_bit%0d: got %b want 1", i, obs[i]); end
    end
    if (obs_t.size() == 16) begin
      total++; if (obs_t[15] - obs_t[0] != 15) begin bad++; $display("FAIL max_contiguous: span got %0d want 15", obs_t[15] - obs_t[0]); end
    end
    total++; if (bus.bit_valid !== 1'b0) begin bad++; $display("FAIL max_valid_end: got %b want 0", bus.bit_valid); end
    total++; if (pulses != 1) begin bad++; $display("FAIL max_run_done: got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    repeat (3) send_symbol(1'($urandom_range(1, 0)), $urandom_range(15, 0), 0, 0);
    idle(1'b1, exp_q.size() + 10);
    total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL b2b_len: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_bit%0d: got %b want %b", i, obs[i], exp_q[i]); end
    end
    if (obs_t.size() > 1) begin
      total++;
      if (obs_t[obs_t.size()-1] - obs_t[0] != obs_t.size() - 1) begin
        bad++; $display("FAIL b2b_contiguous: span got %0d want %0d", obs_t[obs_t.size()-1] - obs_t[0], obs_t.size() - 1);
      end
    end
    total++; if (pulses != 3) begin bad++; $display("FAIL b2b_run_done: got %0d want 3", pulses); end
  endtask

  task automatic test_reset_mid();
    send_symbol(1'b1, 7, 0, 0);   // run loaded and held by rdreq low
    send_bit(1'b1, 0);            // value bit
    send_bit(1'b1, 0);            // two length bits
    send_bit(1'b0, 0);
    apply_reset();
    total++; if (bus.full !== 1'b0)       begin bad++; $display("FAIL rmid_full: got %b want 0", bus.full); end
    total++; if (bus.bit_output !== 1'b0) begin bad++; $display("FAIL rmid_bit_output: got %b want 0", bus.bit_output); end
    total++; if (bus.bit_valid !== 1'b0)  begin bad++; $display("FAIL rmid_bit_valid: got %b want 0", bus.bit_valid); end
    total++; if (bus.run_done !== 1'b0)   begin bad++; $display("FAIL rmid_run_done: got %b want 0", bus.run_done); end
    total++; if (bus.overflow !== 1'b0)   begin bad++; $display("FAIL rmid_overflow: got %b want 0", bus.overflow); end
    total++; if (bus.bit_count !== 16'd0) begin bad++; $display("FAIL rmid_bit_count: got %0d want 0", bus.bit_count); end
    send_symbol(1'b0, 2, 0, 100);
    idle(1'b1, 12);
    total++; if (obs.size() != 3) begin bad++; $display("FAIL rmid_len: got %0d want 3", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      total++; if (obs[i] !== 1'b0) begin bad++; $display("FAIL rmid_bit%0d: got %b want 0", i, obs[i]); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    repeat (40) send_symbol(1'($urandom_range(1, 0)), $urandom_range(15, 0), 2, 70);
    idle(1'b1, 80);
    total++; if (obs.size() != exp_q.size()) begin bad++; $display("FAIL rand_len: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++; if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL rand_bit%0d: got %b want %b", i, obs[i], exp_q[i]); end
    end
    total++; if (pulses != 40) begin bad++; $display("FAIL rand_run_done: got %0d want 40", pulses); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rand_overflow: got %b want 0", bus.overflow); end
    total++; if (bus.bit_count !== 16'(exp_q.size())) begin bad++; $display("FAIL rand_bit_count: got %0d want %0d", bus.bit_count, exp_q.size()); end
    total++; if (bus.bit_valid !== 1'b0) begin bad++; $display("FAIL rand_valid_end: got %b want 0", bus.bit_valid); end
  endtask

  task automatic test_wrap();
    apply_reset();
    record = 1'b0;
    repeat (4096) send_symbol(1'b1, 15, 0, 100);   // 65536 bits
    send_symbol(1'b0, 3, 0, 100);                   // 4 more
    idle(1'b1, 40);
    record = 1'b1;
    total++; if (hs != 65540) begin bad++; $display("FAIL wrap_handshakes: got %0d want 65540", hs); end
    total++; if (bus.bit_count !== 16'd4) begin bad++; $display("FAIL wrap_bit_count: got %0d want 4", bus.bit_count); end
    total++; if (pulses != 4097) begin bad++; $display("FAIL wrap_run_done: got %0d want 4097", pulses); end
  endtask

  initial begin
    bus.wrreq     = 1'b0;
    bus.rdreq     = 1'b0;
    bus.bit_input = 1'b0;
    pulses = 0;
    hs     = 0;
    test_reset();
    test_nominal();
    test_latency();
    test_backpressure();
    test_max_run();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
